meas_seq_ctrl: RTL and testbench
================================

MEAS_SEQ_CTRL -- requirements
Module: meas_seq_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, sample and phase-increment width.
- NUM_CH, 2, number of parallel sample channels.
- MAX_LEN, 1024, maximum capture length in samples per channel.
- CNT_W, $clog2(MAX_LEN)+1, width of the length and counter fields.
- CONFIG_CYCLES, 3, cycles spent in CONFIG; minimum 1.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock.
- rstn, in, 1, asynchronous active-low reset.
- start_config, in, 1, requests configuration.
- phase_inc, in, DATA_WIDTH, NCO increment.
- capture_len, in, CNT_W, samples per channel per frame.
- mode, in, 1, 0 = single-shot, 1 = continuous.
- start_op, in, 1, starts execution.
- abort, in, 1, aborts the current operation.
- restart_vld, in, 1, restart request.
- restart_type, in, 2, 0 REDO, 1 RECONFIG, 2 CLOSE.
- err_clr, in, 1, clears the sticky error bits.
- in_data, in, NUM_CH*DATA_WIDTH, channel samples, channel 0 in the LSBs.
- in_data_vld, in, NUM_CH, per-channel sample valid.
- out_data, out, NUM_CH*DATA_WIDTH, forwarded samples.
- out_data_vld, out, NUM_CH, forwarded valid.
- phase_inc_q, out, DATA_WIDTH, latched increment.
- phase_load, out, 1, one-cycle pulse on CONFIG entry.
- clken, out, 1, high while in EXE.
- finish_op, out, 1, high while in FINISH.
- frame_done, out, 1, one-cycle pulse per completed frame.
- state_out, out, 3, current state encoding.
- err_status, out, 6, sticky error bits.

Function
REQ-003 The block SHALL implement states IDLE=0, CONFIG=1, WAIT_FOR_START=2, EXE=3, FINISH=4; any other encoding SHALL go to IDLE on the next cycle.
REQ-004 In IDLE, start_config with 1<=capture_len<=MAX_LEN SHALL latch phase_inc, capture_len and mode and move to CONFIG; an out-of-range capture_len SHALL stay in IDLE and set err_status[5].
REQ-005 phase_load SHALL pulse in the first cycle of CONFIG. CONFIG SHALL last exactly CONFIG_CYCLES cycles, then move to WAIT_FOR_START.
REQ-006 In WAIT_FOR_START, start_op SHALL move to EXE and clear all channel counters.
REQ-007 In EXE, each channel c SHALL forward the sample when in_data_vld[c] is high and cnt[c] < len_q: out_data_vld[c] asserts in the same cycle (combinational, zero latency) and cnt[c] increments.
REQ-008 out_data SHALL always equal in_data; out_data_vld[c] SHALL be 0 outside EXE and 0 once cnt[c] reaches len_q.
REQ-009 The frame SHALL complete in the cycle after every cnt[c] equals len_q. On completion:
- frame_done pulses.
- Single-shot: move to FINISH.
- Continuous: clear all counters and stay in EXE. A sample arriving in the completion cycle is dropped.
REQ-010 In FINISH, restart_vld SHALL act on restart_type:
- REDO: move to WAIT_FOR_START.
- RECONFIG: move to IDLE.
- CLOSE: move to IDLE and clear phase_inc_q and len_q to 0.
- 3: stay in FINISH and set err_status[4].
REQ-011 abort SHALL move CONFIG, WAIT_FOR_START, EXE and FINISH to IDLE on the next cycle. abort SHALL take priority over every other transition. Latched configuration SHALL be retained.
REQ-012 err_status sticky bits, each set on its event:
- [0]: start_op outside WAIT_FOR_START.
- [1]: start_config outside IDLE.
- [2]: restart_vld outside FINISH.
- [3]: any in_data_vld outside EXE.
REQ-013 err_clr SHALL zero err_status. An error event in the same cycle as err_clr SHALL win (its bit ends set).
REQ-014 Counters SHALL be CNT_W bits wide and SHALL never exceed len_q (no wrap).

Reset
REQ-015 rstn low SHALL asynchronously force the following, and the block SHALL leave reset on the first clk edge after deassertion:
- state = IDLE.
- All counters, phase_inc_q, len_q, mode_q = 0.
- err_status = 0.
- phase_load, frame_done, clken, finish_op, out_data_vld = 0.

Structure
REQ-016 The following SHALL live in a shared package meas_pkg: state encodings, restart_type encodings, err_status bit indices, default DATA_WIDTH.
REQ-017 The per-channel counter and valid gate SHALL be a sub-module ch_capture_cnt, instantiated NUM_CH times by a generate loop.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Basic single-shot: NUM_CH=2, capture_len=4, mode=0, both channels valid every cycle after start_op -> 4 out_data_vld per channel, frame_done once, FINISH 1 cycle later.
- Uneven channels: ch1 valid every other cycle, capture_len=3 -> completion waits for ch1's 3rd sample; ch0 samples beyond 3 are not forwarded.
- Continuous: capture_len=2, mode=1, 10 cycles of full valid -> frame_done pulses 3 times, state remains EXE; abort -> IDLE next cycle.
- Illegal configuration: start_config with capture_len=0, then MAX_LEN+1 -> stays IDLE, err_status[5]=1; err_clr together with start_op in IDLE -> err_status=6'b000001.
- Restart: FINISH + REDO -> WAIT_FOR_START; FINISH + CLOSE -> IDLE with phase_inc_q=0; restart_type=3 -> stays FINISH, err_status[4]=1.
- Reset mid-EXE: rstn low mid-cycle -> every output zero immediately, no clock edge required.

Source files
------------

// File: rtl/meas_pkg.sv
// meas_pkg: shared encodings and constants for the measurement sequencer.
package meas_pkg;

    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONFIG = 3'd1,
        ST_WAIT   = 3'd2,
        ST_EXE    = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        RS_REDO     = 2'd0,
        RS_RECONFIG = 2'd1,
        RS_CLOSE    = 2'd2,
        RS_BAD      = 2'd3
    } restart_e;

    localparam int ERR_START_OP     = 0;
    localparam int ERR_START_CFG    = 1;
    localparam int ERR_RESTART      = 2;
    localparam int ERR_DATA_VLD     = 3;
    localparam int ERR_RESTART_TYPE = 4;
    localparam int ERR_CFG_LEN      = 5;

endpackage

// File: rtl/ch_capture_cnt.sv
// ch_capture_cnt: per-channel sample counter and forward gate.
module ch_capture_cnt #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             vld_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             vld_o,
    output logic             full_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign vld_o  = en_i & vld_i & (cnt_q < len_i);
    assign full_o = cnt_q == len_i;
    assign cnt_d  = clr_i ? '0 : cnt_q + CNT_W'(vld_o);

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;

endmodule

// File: rtl/meas_seq_ctrl.sv
// meas_seq_ctrl: configure / execute / finish sequencer gating NUM_CH sample streams
// into fixed-length frames, with sticky error reporting.
module meas_seq_ctrl
    import meas_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int NUM_CH        = 2,
    parameter int MAX_LEN       = 1024,
    parameter int CNT_W         = $clog2(MAX_LEN) + 1,
    parameter int CONFIG_CYCLES = 3
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start_config,
    input  logic [DATA_WIDTH-1:0]        phase_inc,
    input  logic [CNT_W-1:0]             capture_len,
    input  logic                         mode,
    input  logic                         start_op,
    input  logic                         abort,
    input  logic                         restart_vld,
    input  logic [1:0]                   restart_type,
    input  logic                         err_clr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_data_vld,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]            out_data_vld,
    output logic [DATA_WIDTH-1:0]        phase_inc_q,
    output logic                         phase_load,
    output logic                         clken,
    output logic                         finish_op,
    output logic                         frame_done,
    output logic [2:0]                   state_out,
    output logic [5:0]                   err_status
);

    localparam int CFG_W = $clog2(CONFIG_CYCLES + 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] inc_q, inc_d;
    logic [CNT_W-1:0]      len_q, len_d;
    logic                  mode_q, mode_d;
    logic [CFG_W-1:0]      cfg_q, cfg_d;
    logic [5:0]            err_q, err_d, ev;
    logic [NUM_CH-1:0]     full;
    logic                  exe, cnt_clr, len_ok;

    assign exe         = state_q == ST_EXE;
    assign len_ok      = (capture_len != '0) && (capture_len <= CNT_W'(MAX_LEN));
    assign out_data    = in_data;
    assign phase_inc_q = inc_q;
    assign clken       = exe;
    assign finish_op   = state_q == ST_FINISH;
    assign phase_load  = (state_q == ST_CONFIG) && (cfg_q == '0);
    assign frame_done  = exe & (&full);
    assign state_out   = state_q;
    assign err_status  = err_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_capture_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .rstn   (rstn),
            .en_i   (exe),
            .clr_i  (cnt_clr),
            .vld_i  (in_data_vld[c]),
            .len_i  (len_q),
            .vld_o  (out_data_vld[c]),
            .full_o (full[c])
        );
    end

    always_comb begin
        ev                   = '0;
        ev[ERR_START_OP]     = start_op & (state_q != ST_WAIT);
        ev[ERR_START_CFG]    = start_config & (state_q != ST_IDLE);
        ev[ERR_RESTART]      = restart_vld & ~finish_op;
        ev[ERR_DATA_VLD]     = (|in_data_vld) & ~exe;
        ev[ERR_RESTART_TYPE] = finish_op & restart_vld & (restart_type == RS_BAD);
        ev[ERR_CFG_LEN]      = (state_q == ST_IDLE) & start_config & ~len_ok;
        // A new event beats a simultaneous clear.
        err_d                = (err_clr ? 6'd0 : err_q) | ev;
    end

    always_comb begin
        state_d = state_q;
        inc_d   = inc_q;
        len_d   = len_q;
        mode_d  = mode_q;
        cnt_clr = 1'b0;
        if (abort && state_q != ST_IDLE)
            state_d = ST_IDLE;
        else
            case (state_q)
                ST_IDLE:
                    if (start_config && len_ok) begin
                        state_d = ST_CONFIG;
                        inc_d   = phase_inc;
                        len_d   = capture_len;
                        mode_d  = mode;
                    end
                ST_CONFIG:
                    state_d = (cfg_q == CFG_W'(CONFIG_CYCLES - 1)) ? ST_WAIT : ST_CONFIG;
                ST_WAIT:
                    if (start_op) begin
                        state_d = ST_EXE;
                        cnt_clr = 1'b1;
                    end
                ST_EXE:
                    if (frame_done) begin
                        state_d = mode_q ? ST_EXE : ST_FINISH;
                        cnt_clr = mode_q;
                    end
                ST_FINISH:
                    if (restart_vld) begin
                        state_d = (restart_type == RS_REDO) ? ST_WAIT :
                                  (restart_type == RS_BAD)  ? ST_FINISH : ST_IDLE;
                        inc_d   = (restart_type == RS_CLOSE) ? '0 : inc_q;
                        len_d   = (restart_type == RS_CLOSE) ? '0 : len_q;
                    end
                default:
                    state_d = ST_IDLE;
            endcase
        cfg_d = (state_q == ST_CONFIG && state_d == ST_CONFIG) ? cfg_q + CFG_W'(1) : '0;
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state_q <= ST_IDLE;
            inc_q   <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            cfg_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            inc_q   <= inc_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            cfg_q   <= cfg_d;
            err_q   <= err_d;
        end

endmodule

// File: tb/tb_meas_seq_ctrl.sv
// tb_meas_seq_ctrl: directed scenarios plus random traffic checked against a
// cycle-level behavioural model of the sequencer.
module tb_meas_seq_ctrl;
    import meas_pkg::*;

    localparam int DW = DEF_DATA_WIDTH;
    localparam int NC = 2;
    localparam int ML = 1024;
    localparam int CW = $clog2(ML) + 1;
    localparam int CC = 3;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start_config = 1'b0;
    logic [DW-1:0]     phase_inc = '0;
    logic [CW-1:0]     capture_len = '0;
    logic              mode = 1'b0;
    logic              start_op = 1'b0;
    logic              abort = 1'b0;
    logic              restart_vld = 1'b0;
    logic [1:0]        restart_type = 2'd0;
    logic              err_clr = 1'b0;
    logic [NC*DW-1:0]  in_data = '0;
    logic [NC-1:0]     in_data_vld = '0;
    logic [NC*DW-1:0]  out_data;
    logic [NC-1:0]     out_data_vld;
    logic [DW-1:0]     phase_inc_q;
    logic              phase_load, clken, finish_op, frame_done;
    logic [2:0]        state_out;
    logic [5:0]        err_status;

    meas_seq_ctrl #(
        .DATA_WIDTH(DW), .NUM_CH(NC), .MAX_LEN(ML), .CNT_W(CW), .CONFIG_CYCLES(CC)
    ) dut (
        .clk(clk), .rstn(rstn), .start_config(start_config), .phase_inc(phase_inc),
        .capture_len(capture_len), .mode(mode), .start_op(start_op), .abort(abort),
        .restart_vld(restart_vld), .restart_type(restart_type), .err_clr(err_clr),
        .in_data(in_data), .in_data_vld(in_data_vld), .out_data(out_data),
        .out_data_vld(out_data_vld), .phase_inc_q(phase_inc_q), .phase_load(phase_load),
        .clken(clken), .finish_op(finish_op), .frame_done(frame_done),
        .state_out(state_out), .err_status(err_status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the sequencer: phase 0..4 as named in the requirements,
    // samples taken per channel, config cycles still to spend.
    int            m_st, m_len, m_left;
    int            m_cnt [NC];
    bit            m_mode;
    logic [DW-1:0] m_inc;
    logic [5:0]    m_err;
    int            n_vld [NC];
    int            n_done, done_cyc, cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_len = 0; m_left = 0; m_mode = 0; m_inc = '0; m_err = '0;
        foreach (m_cnt[c]) m_cnt[c] = 0;
    endtask

    task automatic tally_clr();
        foreach (n_vld[c]) n_vld[c] = 0;
        n_done = 0;
        done_cyc = -1;
    endtask

    task automatic idle_in();
        start_config = 0; start_op = 0; abort = 0; restart_vld = 0; err_clr = 0;
        in_data_vld = '0;
        in_data = {$urandom, $urandom};
    endtask

    // Called at a falling edge with inputs applied; checks, advances the model, waits one cycle.
    task automatic step();
        logic [NC-1:0] e_vld;
        logic [5:0]    ev;
        bit            exe, done;
        int            nst;
        #1;
        exe  = m_st == 3;
        done = exe;
        for (int c = 0; c < NC; c++) begin
            if (m_cnt[c] != m_len) done = 0;
            e_vld[c] = exe && in_data_vld[c] && (m_cnt[c] < m_len);
        end
        check("out_data_vld", 64'(out_data_vld), 64'(e_vld));
        check("frame_done",   64'(frame_done),   64'(done));
        check("phase_load",   64'(phase_load),   64'(m_st == 1 && m_left == CC));
        check("clken",        64'(clken),        64'(exe));
        check("finish_op",    64'(finish_op),    64'(m_st == 4));
        check("state_out",    64'(state_out),    64'(m_st));
        check("err_status",   64'(err_status),   64'(m_err));
        check("phase_inc_q",  64'(phase_inc_q),  64'(m_inc));
        check("out_data",     64'(out_data),     64'(in_data));
        for (int c = 0; c < NC; c++) n_vld[c] += int'(out_data_vld[c]);
        if (frame_done) begin
            n_done++;
            done_cyc = cyc;
        end
        cyc++;
        ev    = '0;
        ev[0] = start_op && m_st != 2;
        ev[1] = start_config && m_st != 0;
        ev[2] = restart_vld && m_st != 4;
        ev[3] = (|in_data_vld) && !exe;
        ev[4] = m_st == 4 && restart_vld && restart_type == 2'd3;
        ev[5] = m_st == 0 && start_config && (int'(capture_len) < 1 || int'(capture_len) > ML);
        m_err = (err_clr ? 6'd0 : m_err) | ev;
        if (exe)
            for (int c = 0; c < NC; c++)
                if (done) begin
                    if (m_mode) m_cnt[c] = 0;
                end else if (e_vld[c]) m_cnt[c]++;
        nst = m_st;
        if (abort && m_st != 0) nst = 0;
        else if (m_st == 0) begin
            if (start_config && !ev[5]) begin
                nst = 1; m_inc = phase_inc; m_len = int'(capture_len); m_mode = mode; m_left = CC;
            end
        end else if (m_st == 1) begin
            m_left--;
            if (m_left == 0) nst = 2;
        end else if (m_st == 2) begin
            if (start_op) begin
                nst = 3;
                foreach (m_cnt[c]) m_cnt[c] = 0;
            end
        end else if (m_st == 3) begin
            if (done && !m_mode) nst = 4;
        end else if (m_st == 4 && restart_vld) begin
            if (restart_type == 2'd0) nst = 2;
            else if (restart_type == 2'd1) nst = 0;
            else if (restart_type == 2'd2) begin
                nst = 0; m_inc = '0; m_len = 0;
            end
        end
        m_st = nst;
        @(negedge clk);
        idle_in();
    endtask

    task automatic cfg_run(input int len, input bit md);
        phase_inc = $urandom; capture_len = CW'(len); mode = md; start_config = 1;
        step();
        repeat (CC) step();
        start_op = 1;
        step();
    endtask

    int s;

    initial begin
        model_reset();
        tally_clr();
        cyc = 0;
        idle_in();
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", 64'(state_out), 64'(0));
        check("rst_err", 64'(err_status), 64'(0));
        check("rst_outs", 64'({phase_load, frame_done, clken, finish_op, out_data_vld}), 64'(0));
        @(negedge clk);
        rstn = 1;

        // Basic single-shot
        cfg_run(4, 0);
        tally_clr(); s = cyc;
        for (int i = 0; i < 6; i++) begin in_data_vld = 2'b11; step(); end
        check("s1_vld0", 64'(n_vld[0]), 64'(4));
        check("s1_vld1", 64'(n_vld[1]), 64'(4));
        check("s1_done", 64'(n_done), 64'(1));
        check("s1_done_cyc", 64'(done_cyc - s), 64'(4));
        check("s1_finish", 64'(state_out), 64'(ST_FINISH));
        err_clr = 1; step();
        restart_vld = 1; restart_type = 2'd0; step();
        check("s1_redo", 64'(state_out), 64'(ST_WAIT));

        // Uneven channels
        abort = 1; step();
        cfg_run(3, 0);
        tally_clr(); s = cyc;
        for (int i = 0; i < 8; i++) begin in_data_vld = {(i % 2 == 0), 1'b1}; step(); end
        check("s2_vld0", 64'(n_vld[0]), 64'(3));
        check("s2_vld1", 64'(n_vld[1]), 64'(3));
        check("s2_done", 64'(n_done), 64'(1));
        check("s2_done_cyc", 64'(done_cyc - s), 64'(5));

        // Continuous
        restart_vld = 1; restart_type = 2'd1; step();
        cfg_run(2, 1);
        tally_clr();
        for (int i = 0; i < 10; i++) begin in_data_vld = 2'b11; step(); end
        check("s3_done", 64'(n_done), 64'(3));
        check("s3_exe", 64'(state_out), 64'(ST_EXE));
        abort = 1; step();
        check("s3_abort", 64'(state_out), 64'(ST_IDLE));

        // Illegal configuration
        capture_len = '0; start_config = 1; step();
        check("s4_len0", 64'(state_out), 64'(ST_IDLE));
        capture_len = CW'(ML + 1); start_config = 1; step();
        check("s4_lenmax", 64'(state_out), 64'(ST_IDLE));
        check("s4_err5", 64'(err_status[5]), 64'(1));
        err_clr = 1; start_op = 1; step();
        check("s4_clr_win", 64'(err_status), 64'(6'b000001));

        // Restart handling
        err_clr = 1; step();
        cfg_run(2, 0);
        for (int i = 0; i < 4; i++) begin in_data_vld = 2'b11; step(); end
        check("s5_finish", 64'(state_out), 64'(ST_FINISH));
        restart_vld = 1; restart_type = 2'd3; step();
        check("s5_bad_stay", 64'(state_out), 64'(ST_FINISH));
        check("s5_err4", 64'(err_status[4]), 64'(1));
        restart_vld = 1; restart_type = 2'd0; step();
        check("s5_redo", 64'(state_out), 64'(ST_WAIT));
        start_op = 1; step();
        for (int i = 0; i < 3; i++) begin in_data_vld = 2'b11; step(); end
        restart_vld = 1; restart_type = 2'd2; step();
        check("s5_close", 64'(state_out), 64'(ST_IDLE));
        check("s5_close_inc", 64'(phase_inc_q), 64'(0));

        // Reset in the middle of a frame
        cfg_run(4, 0);
        for (int i = 0; i < 2; i++) begin in_data_vld = 2'b11; step(); end
        in_data_vld = 2'b11;
        #2;
        check("s6_pre_vld", 64'(out_data_vld), 64'(2'b11));
        rstn = 0;
        #1;
        check("s6_state", 64'(state_out), 64'(0));
        check("s6_vld", 64'(out_data_vld), 64'(0));
        check("s6_flags", 64'({phase_load, frame_done, clken, finish_op}), 64'(0));
        check("s6_inc", 64'(phase_inc_q), 64'(0));
        check("s6_err", 64'(err_status), 64'(0));
        model_reset();
        @(negedge clk);
        rstn = 1;
        idle_in();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            start_config = ($urandom_range(0, 7) == 0);
            capture_len  = ($urandom_range(0, 15) == 0) ? CW'(ML + $urandom_range(0, 1))
                                                        : CW'($urandom_range(0, 6));
            phase_inc    = $urandom;
            mode         = 1'($urandom_range(0, 1));
            start_op     = ($urandom_range(0, 5) == 0);
            abort        = ($urandom_range(0, 39) == 0);
            restart_vld  = ($urandom_range(0, 4) == 0);
            restart_type = 2'($urandom_range(0, 3));
            err_clr      = ($urandom_range(0, 15) == 0);
            in_data_vld  = NC'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
